// File: rtl/cpu_pkg.sv
// Shared control-path types for the RV32 pipeline controller.
// Holds the sequencer state encoding and the register-address width.
package cpu_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_WAIT = 2'd1,
      MD_HOLD = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator between the ID operands and the load in EX.
// Purely combinational, zero latency; no flow control of its own.
module load_use_detect
   import cpu_pkg::*;
(
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_reg_write,
   output logic              hazard
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
   assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
   // x0 is never really written, so a load to it cannot create a dependency
   assign hazard  = ex_mem_read && ex_reg_write && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe, with perf counters and mul/div watchdog.
// Controls are combinational from state and inputs; dmem_busy freezes the whole pipe.
module pipe_ctrl
   import cpu_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int MD_TIMEOUT = 64
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_reg_write,
   input  logic              ex_redirect,
   input  logic              ex_md_req,
   output logic              md_go,
   input  logic              md_done,
   input  logic              dmem_busy,
   input  logic              perf_clr,
   output logic              pc_we,
   output logic              ifid_we,
   output logic              ifid_flush,
   output logic              idex_we,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic              md_err
);

   localparam int WD_W = $clog2(MD_TIMEOUT + 1);

   ctrl_state_e     state;
   ctrl_state_e     state_nxt;
   logic [WD_W-1:0] wd_cnt;
   logic            wd_expired;
   logic            md_timeout;
   logic            redirect_ok;
   logic            hazard;

   load_use_detect u_load_use (
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .ex_rd        (ex_rd),
      .ex_mem_read  (ex_mem_read),
      .ex_reg_write (ex_reg_write),
      .hazard       (hazard)
   );

   // wd_cnt holds the number of MD_WAIT cycles already completed
   assign wd_expired = (wd_cnt == WD_W'(MD_TIMEOUT - 1));

   always_comb begin
      state_nxt   = state;
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      md_go       = 1'b0;
      redirect_ok = 1'b0;
      md_timeout  = 1'b0;
      if (dmem_busy) begin
         pc_we   = 1'b0;
         ifid_we = 1'b0;
         idex_we = 1'b0;
         if (state == MD_WAIT && md_done) state_nxt = MD_HOLD;
      end else begin
         case (state)
            RUN: begin
               if (ex_redirect) begin
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  redirect_ok = 1'b1;
               end else if (ex_md_req) begin
                  md_go       = 1'b1;
                  pc_we       = 1'b0;
                  ifid_we     = 1'b0;
                  idex_we     = 1'b0;
                  exmem_flush = 1'b1;
                  state_nxt   = MD_WAIT;
               end else if (hazard) begin
                  pc_we      = 1'b0;
                  ifid_we    = 1'b0;
                  idex_flush = 1'b1;
               end
            end
            MD_WAIT: begin
               if (md_done) begin
                  state_nxt = RUN;
               end else begin
                  pc_we       = 1'b0;
                  ifid_we     = 1'b0;
                  idex_we     = 1'b0;
                  exmem_flush = 1'b1;
                  if (wd_expired) begin
                     md_timeout = 1'b1;
                     state_nxt  = RUN;
                  end
               end
            end
            MD_HOLD: state_nxt = RUN;
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         wd_cnt    <= '0;
         md_err    <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nxt;
         // saturates so a frozen pipe cannot wrap the watchdog
         if (state != MD_WAIT)  wd_cnt <= '0;
         else if (!wd_expired)  wd_cnt <= wd_cnt + WD_W'(1);
         if (md_timeout) md_err <= 1'b1;
         if (perf_clr)                         stall_cnt <= '0;
         else if (!pc_we && stall_cnt != '1)   stall_cnt <= stall_cnt + CNT_W'(1);
         if (perf_clr)                         flush_cnt <= '0;
         else if (redirect_ok && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl against a behavioural pipeline model.
// Inputs change just after the rising edge; outputs are compared on the falling edge.
module tb_pipe_ctrl;

   localparam int CNT_W      = 32;
   localparam int MD_TIMEOUT = 64;
   localparam longint CMAX   = (longint'(1) << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write;
   logic             ex_redirect, ex_md_req, md_done, dmem_busy, perf_clr;
   logic             md_go, pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic             md_err;

   int total  = 0;
   int passed = 0;

   // model: a mul/div is outstanding, or its result is parked behind a busy MEM
   bit     m_pend, m_stuck, m_err;
   int     m_wait;
   longint m_stall, m_flush;
   bit     e_pc, e_ifid, e_idex, e_ifidf, e_idexf, e_exf, e_go, e_acc;

   always #5 clk = ~clk;

   pipe_ctrl #(.CNT_W(CNT_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
      .ex_redirect(ex_redirect), .ex_md_req(ex_md_req), .md_go(md_go), .md_done(md_done),
      .dmem_busy(dmem_busy), .perf_clr(perf_clr),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
      .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .md_err(md_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic predict();
      bit haz;
      if (rst) begin
         m_pend = 0; m_stuck = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
      end
      haz = ex_mem_read && ex_reg_write && (ex_rd != 0) &&
            ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      e_pc = 1; e_ifid = 1; e_idex = 1; e_ifidf = 0; e_idexf = 0; e_exf = 0; e_go = 0; e_acc = 0;
      if (dmem_busy) begin
         e_pc = 0; e_ifid = 0; e_idex = 0;
      end else if (m_pend) begin
         if (!md_done) begin e_pc = 0; e_ifid = 0; e_idex = 0; e_exf = 1; end
      end else if (m_stuck) begin
         e_pc = 1;
      end else if (ex_redirect) begin
         e_ifidf = 1; e_idexf = 1; e_acc = 1;
      end else if (ex_md_req) begin
         e_pc = 0; e_ifid = 0; e_idex = 0; e_exf = 1; e_go = 1;
      end else if (haz) begin
         e_pc = 0; e_ifid = 0; e_idexf = 1;
      end
   endtask

   task automatic advance();
      if (rst) return;
      if (perf_clr) m_stall = 0; else if (!e_pc && m_stall < CMAX) m_stall++;
      if (perf_clr) m_flush = 0; else if (e_acc && m_flush < CMAX) m_flush++;
      if (m_pend) begin
         m_wait++;
         if (md_done) begin m_pend = 0; m_stuck = dmem_busy; end
         else if (m_wait >= MD_TIMEOUT && !dmem_busy) begin m_pend = 0; m_err = 1; end
      end else if (m_stuck) begin
         if (!dmem_busy) m_stuck = 0;
      end else if (e_go) begin
         m_pend = 1; m_wait = 0;
      end
   endtask

   task automatic cycle();
      logic [63:0] m_s, m_f;
      predict();
      m_s = 64'(m_stall);
      m_f = 64'(m_flush);
      @(negedge clk);
      check("ctl", {57'd0, pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_flush, md_go},
                   {57'd0, e_pc, e_ifid, e_idex, e_ifidf, e_idexf, e_exf, e_go});
      check("stall_cnt", 64'(stall_cnt), m_s);
      check("flush_cnt", 64'(flush_cnt), m_f);
      check("md_err", 64'(md_err), 64'(m_err));
      @(posedge clk);
      advance();
      #1;
   endtask

   task automatic idle_inputs();
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
      ex_mem_read = 0; ex_reg_write = 0; ex_redirect = 0; ex_md_req = 0;
      md_done = 0; dmem_busy = 0; perf_clr = 0;
   endtask

   initial begin
      rst = 0;
      idle_inputs();
      #1 rst = 1;
      cycle(); cycle();
      rst = 0;
      cycle();

      // load-use on rs1, then the load moves on
      ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
      cycle();
      check("ld_use_stall", 64'(stall_cnt), 64'd1);
      ex_mem_read = 0;
      cycle();

      // same dependency through x0 never stalls
      ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
      cycle(); cycle();

      // redirect beats mul/div and load-use in one cycle
      ex_rd = 5; id_rs1 = 5; ex_redirect = 1; ex_md_req = 1;
      cycle();
      check("redir_flush", 64'(flush_cnt), 64'd1);
      idle_inputs();
      perf_clr = 1;
      cycle();
      perf_clr = 0;

      // mul/div with md_done four cycles after md_go
      ex_md_req = 1;
      repeat (4) cycle();
      md_done = 1;
      cycle();
      check("md_stall", 64'(stall_cnt), 64'd4);
      md_done = 0; ex_md_req = 0;
      cycle();

      // md_done while MEM is busy, then three frozen hold cycles
      ex_md_req = 1;
      repeat (2) cycle();
      md_done = 1; dmem_busy = 1;
      cycle();
      md_done = 0;
      repeat (3) cycle();
      dmem_busy = 0;
      cycle();
      ex_md_req = 0;
      cycle(); cycle();

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         id_rs1       = 5'($urandom_range(0, 3));
         id_rs2       = 5'($urandom_range(0, 3));
         ex_rd        = 5'($urandom_range(0, 3));
         id_use_rs1   = 1'($urandom_range(0, 1));
         id_use_rs2   = 1'($urandom_range(0, 1));
         ex_mem_read  = 1'($urandom_range(0, 1));
         ex_reg_write = 1'($urandom_range(0, 1));
         ex_redirect  = ($urandom_range(0, 5) == 0);
         ex_md_req    = ($urandom_range(0, 4) == 0);
         md_done      = ($urandom_range(0, 3) == 0);
         dmem_busy    = ($urandom_range(0, 3) == 0);
         perf_clr     = ($urandom_range(0, 29) == 0);
         cycle();
      end
      idle_inputs();
      repeat (MD_TIMEOUT + 4) cycle();

      // mul/div that never completes trips the watchdog
      ex_md_req = 1;
      cycle();
      ex_md_req = 0;
      repeat (MD_TIMEOUT) cycle();
      check("md_err_set", 64'(md_err), 64'd1);
      repeat (5) cycle();
      check("md_err_sticky", 64'(md_err), 64'd1);

      // reset in the middle of a mul/div, then a late md_done
      ex_md_req = 1;
      repeat (3) cycle();
      rst = 1; ex_md_req = 0;
      cycle();
      rst = 0; md_done = 1;
      cycle();
      md_done = 0;
      cycle();
      check("rst_md_err", 64'(md_err), 64'd0);
      check("rst_stall", 64'(stall_cnt), 64'd0);
      check("rst_flush", 64'(flush_cnt), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
